// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared bus widths and arbiter state encoding
package cpu16_pkg;
    localparam int AW = 9;
    localparam int BW = 16;
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, DMA and main-memory signals around the arbiter
interface mem_arbiter_if #(
    parameter int AW = cpu16_pkg::AW,
    parameter int BW = cpu16_pkg::BW
);
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [BW-1:0] cpu_wdata;
    logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [BW-1:0] dma_wdata;
    logic [BW-1:0] rdata;
    logic          lock_active;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data;
    logic          mem_wren;
    logic [BW-1:0] mem_q;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock, mem_q,
        output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata, lock_active,
        output mem_addr, mem_data, mem_wren
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock, mem_q,
        input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata, lock_active,
        input  mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating up-counter; clr wins over inc, hit flags saturation
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= clr ? '0 : (inc && cnt != W'(MAX)) ? cnt + 1'b1 : cnt;
    assign hit = cnt == W'(MAX);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority CPU/DMA sharing of single-port memory with
// DMA anti-starvation and bounded DMA lock bursts
module mem_arbiter import cpu16_pkg::*; #(
    parameter int AW         = cpu16_pkg::AW,
    parameter int BW         = cpu16_pkg::BW,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    arb_state_t    state;
    logic          locked, wait_hit, lock_hit, blk;
    logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic          timeout, lock_enter, lock_exit;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;

    assign locked     = state == LOCKED;
    assign cpu_gnt    = rst & !locked & bus.cpu_req & !(wait_hit & bus.dma_req);
    assign dma_gnt    = rst & bus.dma_req & (locked | wait_hit | !bus.cpu_req);
    assign timeout    = locked & lock_hit;
    assign lock_exit  = locked & (!bus.dma_lock | lock_hit);
    assign lock_enter = !locked & dma_gnt & bus.dma_lock & !blk;

    // idle cycles present the CPU address as a harmless read
    assign addr  = !rst ? '0 : dma_gnt ? bus.dma_addr : bus.cpu_addr;
    assign wdata = !rst ? '0 : dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.mem_addr    = addr;
    assign bus.mem_data    = wdata;
    assign bus.mem_wren    = (cpu_gnt & bus.cpu_we) | (dma_gnt & bus.dma_we);
    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.dma_gnt     = dma_gnt;
    assign bus.cpu_rvalid  = cpu_rvalid;
    assign bus.dma_rvalid  = dma_rvalid;
    assign bus.rdata       = bus.mem_q;
    assign bus.lock_active = locked;

    arb_starve_cnt #(.MAX(STARVE_MAX)) u_wait (
        .clk(clk),
        .rst(rst),
        .inc(bus.dma_req & !dma_gnt),
        .clr(!bus.dma_req | dma_gnt | timeout),
        .hit(wait_hit)
    );

    // zero while arbitrating, so the entry increment loads 1
    arb_starve_cnt #(.MAX(LOCK_MAX)) u_lock (
        .clk(clk),
        .rst(rst),
        .inc(lock_enter | (locked & !lock_exit)),
        .clr(lock_exit),
        .hit(lock_hit)
    );

    // blk defers relock after a timeout until the CPU has had a priority cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= ARB;
            blk        <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            state      <= lock_enter ? LOCKED : lock_exit ? ARB : state;
            blk        <= timeout | (blk & (locked | (wait_hit & bus.dma_req)));
            cpu_rvalid <= cpu_gnt & !bus.cpu_we;
            dma_rvalid <= dma_gnt & !bus.dma_we;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a per-cycle behavioural model check
module tb_mem_arbiter;
    import cpu16_pkg::*;
    localparam int STARVE = 4;
    localparam int LMAX   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter #(.STARVE_MAX(STARVE), .LOCK_MAX(LMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [BW-1:0] ram     [2**AW];
    logic [BW-1:0] mdl_mem [2**AW];
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        bus.mem_q <= ram[bus.mem_addr];
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit            m_locked, m_blk, pend_c, pend_d;
    int            m_wait, m_lockc;
    logic [BW-1:0] pend_data;
    bit            e_cg, e_dg, e_we;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_wd;

    always @(negedge clk) begin
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (rst) begin
            if (m_locked) e_dg = bus.dma_req;
            else if (m_wait == STARVE && bus.dma_req) e_dg = 1'b1;
            else if (bus.cpu_req) e_cg = 1'b1;
            else e_dg = bus.dma_req;
        end
        e_addr = !rst ? '0 : e_dg ? bus.dma_addr : bus.cpu_addr;
        e_wd   = e_dg ? bus.dma_wdata : bus.cpu_wdata;
        e_we   = (e_cg && bus.cpu_we) || (e_dg && bus.dma_we);
        chk("m_cpu_gnt", bus.cpu_gnt, e_cg);
        chk("m_dma_gnt", bus.dma_gnt, e_dg);
        chk("m_wren", bus.mem_wren, e_we);
        chk("m_addr", bus.mem_addr, e_addr);
        if (e_cg || e_dg) chk("m_data", bus.mem_data, e_wd);
        if (!rst) chk("m_rst_data", bus.mem_data, 0);
        chk("m_cpu_rvalid", bus.cpu_rvalid, pend_c);
        chk("m_dma_rvalid", bus.dma_rvalid, pend_d);
        if (pend_c || pend_d) chk("m_rdata", bus.rdata, pend_data);
        chk("m_lock_active", bus.lock_active, m_locked);
    end

    always @(posedge clk or negedge rst)
        if (!rst) begin
            m_locked <= 0;
            m_blk    <= 0;
            pend_c   <= 0;
            pend_d   <= 0;
            m_wait   <= 0;
            m_lockc  <= 0;
        end else begin
            pend_c    <= e_cg && !bus.cpu_we;
            pend_d    <= e_dg && !bus.dma_we;
            pend_data <= mdl_mem[e_addr];
            if (e_we) mdl_mem[e_addr] <= e_wd;
            m_wait <= (bus.dma_req && !e_dg) ? (m_wait < STARVE ? m_wait + 1 : STARVE) : 0;
            if (!m_locked) begin
                if (e_dg && bus.dma_lock && !m_blk) begin
                    m_locked <= 1;
                    m_lockc  <= 1;
                end
                if (!(m_wait == STARVE && bus.dma_req)) m_blk <= 0;
            end else if (m_lockc == LMAX || !bus.dma_lock) begin
                m_locked <= 0;
                if (m_lockc == LMAX) begin
                    m_blk  <= 1;
                    m_wait <= 0;
                end
            end else m_lockc <= m_lockc + 1;
        end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        bus.cpu_req   = r;
        bus.cpu_we    = w;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic dma(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [BW-1:0] d);
        bus.dma_req   = r;
        bus.dma_we    = w;
        bus.dma_lock  = l;
        bus.dma_addr  = a;
        bus.dma_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram[i]     = BW'(i) ^ 16'h5A5A;
            mdl_mem[i] = BW'(i) ^ 16'h5A5A;
        end
        cpu(1, 0, 9'h033, 0);
        dma(1, 1, 0, 9'h044, 16'h1234);
        mid();
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_dma_gnt", bus.dma_gnt, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_lock", bus.lock_active, 0);
        nxt();
        rst = 1'b1;
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0, 0);
        mid();
        chk("idle_cpu_gnt", bus.cpu_gnt, 0);
        chk("idle_dma_gnt", bus.dma_gnt, 0);
        chk("idle_rvalid", bus.cpu_rvalid, 0);
        nxt();
        // CPU wins a simultaneous request
        cpu(1, 0, 9'h010, 0);
        dma(1, 0, 0, 9'h020, 0);
        mid();
        chk("pri_cpu_gnt", bus.cpu_gnt, 1);
        chk("pri_dma_gnt", bus.dma_gnt, 0);
        chk("pri_addr", bus.mem_addr, 9'h010);
        nxt();
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0, 0);
        mid();
        chk("pri_rvalid", bus.cpu_rvalid, 1);
        chk("pri_rdata", bus.rdata, 16'h5A4A);
        nxt();
        // starvation: DMA wins on the fifth contended cycle
        cpu(1, 0, 9'h011, 0);
        dma(1, 0, 0, 9'h030, 0);
        for (int k = 1; k <= 6; k++) begin
            mid();
            chk("starve_dma_gnt", bus.dma_gnt, k == 5);
            chk("starve_cpu_gnt", bus.cpu_gnt, k != 5);
            if (k == 6) begin
                chk("starve_dma_rvalid", bus.dma_rvalid, 1);
                chk("starve_rdata", bus.rdata, 16'h5A6A);
            end
            nxt();
        end
        // locked DMA write burst
        for (int i = 0; i < 8; i++) begin
            cpu(i > 0, 0, 9'h050, 0);
            dma(1, 1, 1, 9'h100 + 9'(i), 16'hA000 + 16'(i));
            mid();
            chk("burst_dma_gnt", bus.dma_gnt, 1);
            if (i > 0) begin
                chk("burst_lock", bus.lock_active, 1);
                chk("burst_cpu_gnt", bus.cpu_gnt, 0);
            end
            nxt();
        end
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0, 0);
        mid();
        chk("burst_lock_hold", bus.lock_active, 1);
        nxt();
        for (int i = 0; i <= 8; i++) begin
            cpu(i < 8, 0, 9'h100 + 9'(i), 0);
            mid();
            if (i == 0) chk("burst_lock_fall", bus.lock_active, 0);
            else chk("readback", bus.rdata, 16'hA000 + 16'(i - 1));
            nxt();
        end
        // lock timeout with CPU contending
        cpu(1, 0, 9'h005, 0);
        dma(1, 0, 1, 9'h006, 0);
        for (int c = 1; c <= 27; c++) begin
            mid();
            if (c <= 4) chk("to_denied", bus.dma_gnt, 0);
            if (c == 5) chk("to_win", bus.dma_gnt, 1);
            if (c >= 6 && c <= 21) chk("to_locked", bus.lock_active, 1);
            if (c == 22) begin
                chk("to_exit", bus.lock_active, 0);
                chk("to_cpu_gnt", bus.cpu_gnt, 1);
            end
            if (c == 26) chk("to_relock_gnt", bus.dma_gnt, 1);
            if (c == 27) chk("to_relock", bus.lock_active, 1);
            nxt();
        end
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0, 0);
        nxt();
        nxt();
        // relock deferral with no CPU traffic
        dma(1, 0, 1, 9'h007, 0);
        for (int c = 1; c <= 20; c++) begin
            mid();
            if (c == 17) chk("def_locked", bus.lock_active, 1);
            if (c == 18) begin
                chk("def_exit", bus.lock_active, 0);
                chk("def_dma_gnt", bus.dma_gnt, 1);
            end
            if (c == 19) chk("def_deferred", bus.lock_active, 0);
            if (c == 20) chk("def_relock", bus.lock_active, 1);
            nxt();
        end
        dma(0, 0, 0, 0, 0);
        nxt();
        nxt();
        // asynchronous reset while a read result is pending
        cpu(1, 0, 9'h020, 0);
        dma(1, 0, 0, 9'h021, 0);
        mid();
        chk("ar_gnt", bus.cpu_gnt, 1);
        nxt();
        mid();
        chk("ar_pending", bus.cpu_rvalid, 1);
        rst = 1'b0;
        #1;
        chk("ar_rvalid", bus.cpu_rvalid, 0);
        chk("ar_cpu_gnt", bus.cpu_gnt, 0);
        chk("ar_dma_gnt", bus.dma_gnt, 0);
        chk("ar_lock", bus.lock_active, 0);
        rst = 1'b1;
        nxt();
        for (int k = 2; k <= 5; k++) begin
            mid();
            chk("ar_wait_dma_gnt", bus.dma_gnt, k == 5);
            nxt();
        end
        cpu(0, 0, 0, 0);
        dma(0, 0, 0, 0, 0);
        nxt();
        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory between two requesters: the CPU (requester 0) and a DMA/program loader (requester 1).
- Sits between cpu16's memory interface and MM. It drives MM's address, data and write-enable, and returns MM's q to the requester that issued each read.
- CPU has fixed priority. DMA is protected from starvation by a wait counter, and can lock the memory for bursts up to a bounded length.

Parameters:
- AW, 9, memory address width
- BW, 16, data width
- STARVE_MAX, 4, consecutive cycles of denied DMA request before DMA is forced to win
- LOCK_MAX, 16, maximum cycles the DMA may hold a lock

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (one access per granted cycle)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  BW  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid on rdata (registered)
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write
- dma_addr  in  AW  DMA address
- dma_wdata  in  BW  DMA write data
- dma_lock  in  1  DMA requests exclusive ownership
- dma_gnt  out  1  DMA access accepted this cycle (combinational)
- dma_rvalid  out  1  DMA read data valid on rdata (registered)
- rdata  out  BW  read data, equal to mem_q
- lock_active  out  1  FSM is in LOCKED (registered)
- mem_addr  out  AW  to MM address
- mem_data  out  BW  to MM data
- mem_wren  out  1  to MM wren
- mem_q  in  BW  from MM q; valid one cycle after the address edge

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to ARB; wait_cnt and lock_cnt clear to 0.
  - cpu_rvalid, dma_rvalid and lock_active are 0.
  - While rst=0, cpu_gnt, dma_gnt and mem_wren are forced to 0; mem_addr and mem_data are 0.
- Arbitration (combinational, in the same cycle as the request):
  - In ARB: if wait_cnt==STARVE_MAX and dma_req, then dma_gnt=1. Otherwise cpu_req gives cpu_gnt=1, else dma_req gives dma_gnt=1.
  - In LOCKED: cpu_gnt=0 always; dma_gnt=dma_req.
  - At most one grant per cycle.
- Memory mux:
  - The granted requester's addr and wdata drive mem_addr and mem_data.
  - mem_wren = gnt & we of the granted requester.
  - With no grant: mem_wren=0 and mem_addr holds the CPU's address, so a no-grant cycle is a harmless read.
- Read latency:
  - A read granted in cycle N gives x_rvalid=1 for exactly cycle N+1, with rdata=mem_q.
  - Writes never assert rvalid.
  - Back-to-back reads give rvalid on consecutive cycles.
- wait_cnt:
  - Increments, saturating at STARVE_MAX, on each cycle with dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or when dma_req=0.
- FSM ARB -> LOCKED: on a cycle with dma_gnt=1 and dma_lock=1. lock_cnt is loaded with 1 on entry.
- FSM in LOCKED:
  - lock_cnt increments every cycle.
  - Exit to ARB at the end of a cycle where dma_lock=0 or lock_cnt==LOCK_MAX.
  - The exit cycle's DMA access, if requested, is still granted.
  - After a timeout exit, wait_cnt is cleared and DMA cannot re-enter LOCKED until after one ARB cycle in which the CPU was given priority.
  - dma_req=0 inside LOCKED is legal: no grant, the lock is held, and the counter keeps running.
- Reset mid-operation: a pending read's rvalid is dropped and is not replayed.

Decomposition:
- Shared package `cpu16_pkg`: AW and BW defaults, and the state encoding (ARB=1'b0, LOCKED=1'b1).
- Sub-module `arb_starve_cnt`: a saturating counter with inc, clr and hit, reused for both wait_cnt and lock_cnt.

Test Plan:
- Reset then idle: rst=0 -> all grants, rvalid and mem_wren are 0. After rst=1 with no requests -> still 0.
- CPU read priority: cpu_req and dma_req both 1, addr 0x010 -> cpu_gnt=1, dma_gnt=0, and next cycle cpu_rvalid=1 with rdata=mem[0x010].
- Starvation: cpu_req held at 1 and dma_req held at 1 -> DMA is denied 4 cycles, dma_gnt=1 on the 5th, then the CPU resumes.
- DMA burst: dma_lock=1 and writes 0xA000..0xA007 to 0x100..0x107 -> lock_active=1 and cpu_gnt=0 throughout. Readback of those addresses matches, then lock_active falls when dma_lock=0.
- Lock timeout: dma_lock held at 1 with cpu_req=1 -> exit to ARB after 16 cycles, the CPU is granted the next cycle, and relock is deferred as specified.
- Async reset during read: a read is granted, then rst=0 pulses mid-cycle -> no rvalid, the FSM is in ARB, and the counters are 0.
